// File: rtl/peripheral_biu_pkg.sv
// Shared BIU definitions: arbiter state encoding, TileLink-style burst/size codes
// and a small index-width helper used by the SPRAM arbiter.
package peripheral_biu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  // Burst types
  localparam logic [2:0] TL_SINGLE = 3'd0;
  localparam logic [2:0] TL_INCR   = 3'd1;
  localparam logic [2:0] TL_WRAP4  = 3'd2;
  localparam logic [2:0] TL_INCR4  = 3'd3;
  localparam logic [2:0] TL_WRAP8  = 3'd4;
  localparam logic [2:0] TL_INCR8  = 3'd5;
  localparam logic [2:0] TL_WRAP16 = 3'd6;
  localparam logic [2:0] TL_INCR16 = 3'd7;

  // Transfer sizes (log2 of byte count)
  localparam logic [2:0] TL_BYTE  = 3'd0;
  localparam logic [2:0] TL_HWORD = 3'd1;
  localparam logic [2:0] TL_WORD  = 3'd2;
  localparam logic [2:0] TL_DWORD = 3'd3;
  localparam logic [2:0] TL_QWORD = 3'd4;

  // Bits needed to index n items, never less than one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/peripheral_spram_rr_arbiter_tl.sv
// Combinational round-robin picker: one-hot grant of the first requester at or
// after the pointer, searching upward with wrap-around.
module peripheral_spram_rr_arbiter_tl #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_i) + i) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/peripheral_spram_arbiter_tl.sv
// Round-robin arbiter sharing one TileLink-style BIU slave between NUM_MASTERS
// requesters, one outstanding transfer, lock hold and a response watchdog.
module peripheral_spram_arbiter_tl
  import peripheral_biu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int PLEN        = 64,
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  output logic [NUM_MASTERS-1:0]      m_stb_ack_o,
  input  logic [NUM_MASTERS*PLEN-1:0] m_adri_i,
  input  logic [NUM_MASTERS*3-1:0]    m_size_i,
  input  logic [NUM_MASTERS*3-1:0]    m_type_i,
  input  logic [NUM_MASTERS*3-1:0]    m_prot_i,
  input  logic [NUM_MASTERS-1:0]      m_lock_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS*XLEN-1:0] m_d_i,
  output logic [XLEN-1:0]             m_q_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic                        s_stb_o,
  input  logic                        s_stb_ack_i,
  output logic [PLEN-1:0]             s_adri_o,
  output logic [2:0]                  s_size_o,
  output logic [2:0]                  s_type_o,
  output logic [2:0]                  s_prot_o,
  output logic                        s_lock_o,
  output logic                        s_we_o,
  output logic [XLEN-1:0]             s_d_o,
  input  logic [XLEN-1:0]             s_q_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  output logic [NUM_MASTERS-1:0]      gnt_o
);

  localparam int PTRW = idx_w(NUM_MASTERS);
  localparam int WDW  = idx_w(TIMEOUT + 1);
  localparam logic [WDW-1:0]  WD_LAST = WDW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [PTRW-1:0] LAST_M  = PTRW'(NUM_MASTERS - 1);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [PTRW-1:0]        ptr_q, ptr_d;
  logic [PTRW-1:0]        own_q, own_d;
  logic [WDW-1:0]         wdog_q, wdog_d;

  logic [NUM_MASTERS-1:0] pick;
  logic [PTRW-1:0]        pick_idx;
  logic [PTRW-1:0]        ptr_next;
  logic                   own_stb, own_lock, s_done, wd_fire;

  peripheral_spram_rr_arbiter_tl #(
    .N  (NUM_MASTERS),
    .PW (PTRW)
  ) u_rr (
    .req_i (m_stb_i),
    .ptr_i (ptr_q),
    .gnt_o (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick[i]) pick_idx = PTRW'(i);
    end
  end

  assign own_stb  = m_stb_i[own_q];
  assign own_lock = m_lock_i[own_q];
  assign s_done   = s_ack_i | s_err_i;
  assign ptr_next = (own_q == LAST_M) ? '0 : own_q + 1'b1;

  // Fires in the WAIT cycle that would count the TIMEOUT-th unanswered cycle;
  // a slave response arriving in that same cycle still takes precedence.
  assign wd_fire  = (TIMEOUT != 0) && !s_done && (wdog_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      own_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      IDLE: begin
        if (|m_stb_i) begin
          state_d = REQ;
          gnt_d   = pick;
          own_d   = pick_idx;
        end
      end
      REQ: begin
        if (!own_stb) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (s_stb_ack_i) begin
          state_d = WAIT;
          wdog_d  = '0;
        end
      end
      WAIT: begin
        if (s_done) begin
          if (own_lock && own_stb) begin
            state_d = REQ;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = ptr_next;
          end
        end else if (wd_fire) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_next;
        end else if (TIMEOUT != 0) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // The owner mux is AND-OR on the one-hot grant, so everything reads zero when idle.
  always_comb begin
    s_adri_o = '0;
    s_size_o = '0;
    s_type_o = '0;
    s_prot_o = '0;
    s_lock_o = 1'b0;
    s_we_o   = 1'b0;
    s_d_o    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_q[i]) begin
        s_adri_o = s_adri_o | m_adri_i[i*PLEN +: PLEN];
        s_size_o = s_size_o | m_size_i[i*3 +: 3];
        s_type_o = s_type_o | m_type_i[i*3 +: 3];
        s_prot_o = s_prot_o | m_prot_i[i*3 +: 3];
        s_lock_o = s_lock_o | m_lock_i[i];
        s_we_o   = s_we_o | m_we_i[i];
        s_d_o    = s_d_o | m_d_i[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    s_stb_o     = 1'b0;
    m_stb_ack_o = '0;
    m_ack_o     = '0;
    m_err_o     = '0;
    m_q_o       = '0;
    if (state_q == REQ) begin
      s_stb_o     = own_stb;
      m_stb_ack_o = gnt_q & {NUM_MASTERS{s_stb_ack_i}};
    end
    if (state_q == WAIT) begin
      m_q_o = s_q_i;
      if (s_err_i || wd_fire) m_err_o = gnt_q;
      else if (s_ack_i)       m_ack_o = gnt_q;
    end
  end

  assign gnt_o = gnt_q;

endmodule

// File: tb/tb_peripheral_spram_arbiter_tl.sv
// Bench for the round-robin SPRAM arbiter: scenario tasks with a behavioural
// slave and a round-robin reference model of grant order.
module tb_peripheral_spram_arbiter_tl;

  localparam int N  = 2;
  localparam int XL = 64;
  localparam int PL = 64;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_stb_i, m_stb_ack_o, m_lock_i, m_we_i, m_ack_o, m_err_o, gnt_o;
  logic [N*PL-1:0] m_adri_i;
  logic [N*3-1:0]  m_size_i, m_type_i, m_prot_i;
  logic [N*XL-1:0] m_d_i;
  logic [XL-1:0]   m_q_o;
  logic            s_stb_o, s_stb_ack_i, s_lock_o, s_we_o, s_ack_i, s_err_i;
  logic [PL-1:0]   s_adri_o;
  logic [2:0]      s_size_o, s_type_o, s_prot_o;
  logic [XL-1:0]   s_d_o, s_q_i;

  int checks   = 0;
  int failures = 0;
  int model_ptr = 0;
  logic [PL-1:0] exp_adr [N];
  logic [XL-1:0] exp_d   [N];
  logic          exp_we  [N];

  peripheral_spram_arbiter_tl #(
    .XLEN(XL), .PLEN(PL), .NUM_MASTERS(N), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_stb_i(m_stb_i), .m_stb_ack_o(m_stb_ack_o), .m_adri_i(m_adri_i),
    .m_size_i(m_size_i), .m_type_i(m_type_i), .m_prot_i(m_prot_i),
    .m_lock_i(m_lock_i), .m_we_i(m_we_i), .m_d_i(m_d_i), .m_q_o(m_q_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_stb_o(s_stb_o), .s_stb_ack_i(s_stb_ack_i), .s_adri_o(s_adri_o),
    .s_size_o(s_size_o), .s_type_o(s_type_o), .s_prot_o(s_prot_o),
    .s_lock_o(s_lock_o), .s_we_o(s_we_o), .s_d_o(s_d_o), .s_q_i(s_q_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "bench timeout");
  end

  // Reference: first requester at or after ptr, wrapping upward.
  function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int o);
    logic [N-1:0] v;
    v = '0;
    if (o >= 0 && o < N) v[o] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int i, input logic stb, input logic [PL-1:0] a,
                         input logic we, input logic lk, input logic [XL-1:0] d);
    m_stb_i[i]          = stb;
    m_adri_i[i*PL +: PL] = a;
    m_we_i[i]           = we;
    m_lock_i[i]         = lk;
    m_d_i[i*XL +: XL]   = d;
    m_size_i[i*3 +: 3]  = 3'($urandom_range(0, 3));
    m_type_i[i*3 +: 3]  = 3'($urandom_range(0, 7));
    m_prot_i[i*3 +: 3]  = 3'($urandom_range(0, 7));
    exp_adr[i] = a;
    exp_d[i]   = d;
    exp_we[i]  = we;
  endtask

  // Behavioural slave: accepts the strobe, responds after lat WAIT cycles.
  // mode 0: ack, 1: never respond, 2: ack and err together.
  task automatic slave_serve(input int lat, input int mode, input logic [XL-1:0] q,
                             output int owner, output int arb_cyc,
                             output logic [PL-1:0] adr, output logic [XL-1:0] wdat,
                             output logic we, output logic [N-1:0] sack,
                             output logic [N-1:0] ack, output logic [N-1:0] err,
                             output logic [XL-1:0] qo, output int resp_cyc);
    int lim;
    s_stb_ack_i = 1'b0; s_ack_i = 1'b0; s_err_i = 1'b0; s_q_i = '0;
    arb_cyc = 0;
    #1;
    while (s_stb_o !== 1'b1 && arb_cyc < 20) begin
      step();
      #1;
      arb_cyc++;
    end
    owner = -1;
    for (int i = 0; i < N; i++) if (gnt_o[i] === 1'b1) owner = i;
    adr  = s_adri_o;
    wdat = s_d_o;
    we   = s_we_o;
    s_stb_ack_i = 1'b1;
    #1;
    sack = m_stb_ack_o;
    step();
    s_stb_ack_i = 1'b0;
    ack = '0; err = '0; qo = '0; resp_cyc = 0;
    lim = (mode == 1) ? 12 : lat;
    for (int k = 1; k <= lim; k++) begin
      if (k == lat && mode != 1) begin
        s_ack_i = 1'b1;
        s_err_i = (mode == 2);
        s_q_i   = q;
      end
      #1;
      if (m_ack_o !== '0 || m_err_o !== '0) begin
        ack = m_ack_o; err = m_err_o; qo = m_q_o; resp_cyc = k;
      end
      step();
      s_ack_i = 1'b0; s_err_i = 1'b0; s_q_i = '0;
      if (resp_cyc != 0) break;
    end
  endtask

  task automatic test_reset();
    logic [XL-1:0] q;
    rst = 1'b1;
    m_stb_i = '0; m_lock_i = '0; m_we_i = '0; m_adri_i = '0; m_d_i = '0;
    m_size_i = '0; m_type_i = '0; m_prot_i = '0;
    s_stb_ack_i = 1'b0; s_ack_i = 1'b0; s_err_i = 1'b0; s_q_i = '0;
    repeat (2) step();
    drive_m(0, 1'b1, rnd64() | 64'h1, 1'b1, 1'b1, rnd64());
    drive_m(1, 1'b1, rnd64() | 64'h1, 1'b1, 1'b1, rnd64());
    q = rnd64() | 64'h1;
    s_ack_i = 1'b1; s_q_i = q;
    step();
    rst = 1'b0;
    #1;
    checks++; if (gnt_o !== '0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", gnt_o); end
    checks++; if (s_stb_o !== 1'b0) begin failures++; $display("FAIL reset_s_stb got=%b exp=0", s_stb_o); end
    checks++; if (m_ack_o !== '0 || m_err_o !== '0) begin failures++; $display("FAIL reset_ack_err got=%b/%b exp=0", m_ack_o, m_err_o); end
    checks++; if (m_q_o !== '0) begin failures++; $display("FAIL reset_m_q got=%h exp=0", m_q_o); end
    checks++; if (s_adri_o !== '0 || s_d_o !== '0 || s_we_o !== 1'b0 || s_lock_o !== 1'b0)
      begin failures++; $display("FAIL reset_s_bus got adr=%h d=%h we=%b lk=%b exp=0", s_adri_o, s_d_o, s_we_o, s_lock_o); end
    checks++; if (m_stb_ack_o !== '0) begin failures++; $display("FAIL reset_stb_ack got=%b exp=0", m_stb_ack_o); end
    m_stb_i = '0; s_ack_i = 1'b0; s_q_i = '0;
    model_ptr = 0;
    step();
  endtask

  task automatic test_single();
    int owner, arb, rc; logic [PL-1:0] adr; logic [XL-1:0] wd, qo; logic we;
    logic [N-1:0] sack, ack, err;
    drive_m(0, 1'b1, 64'h100, 1'b0, 1'b0, rnd64());
    slave_serve(2, 0, 64'hDEAD, owner, arb, adr, wd, we, sack, ack, err, qo, rc);
    m_stb_i[0] = 1'b0;
    checks++; if (arb !== 1) begin failures++; $display("FAIL single_arb_cycles got=%0d exp=1", arb); end
    checks++; if (owner !== 0) begin failures++; $display("FAIL single_owner got=%0d exp=0", owner); end
    checks++; if (adr !== 64'h100 || we !== 1'b0) begin failures++; $display("FAIL single_addr got=%h we=%b exp=100 we=0", adr, we); end
    checks++; if (sack !== 2'b01) begin failures++; $display("FAIL single_stb_ack got=%b exp=01", sack); end
    checks++; if (rc !== 2 || ack !== 2'b01 || err !== 2'b00)
      begin failures++; $display("FAIL single_ack got cyc=%0d ack=%b err=%b exp cyc=2 ack=01 err=00", rc, ack, err); end
    checks++; if (qo !== 64'hDEAD) begin failures++; $display("FAIL single_q got=%h exp=dead", qo); end
    #1;
    checks++; if (gnt_o !== '0) begin failures++; $display("FAIL single_gnt_idle got=%b exp=0", gnt_o); end
    model_ptr = 1;
    drive_m(0, 1'b1, rnd64(), 1'b0, 1'b0, rnd64());
    drive_m(1, 1'b1, rnd64(), 1'b0, 1'b0, rnd64());
    slave_serve(1, 0, rnd64(), owner, arb, adr, wd, we, sack, ack, err, qo, rc);
    m_stb_i = '0;
    checks++; if (owner !== 1) begin failures++; $display("FAIL single_ptr_next_owner got=%0d exp=1", owner); end
    model_ptr = 0;
    step();
  endtask

  task automatic test_alternate();
    int rem [N]; int prev, exp_o, owner, arb, rc;
    logic [PL-1:0] adr; logic [XL-1:0] wd, qo, q; logic we; logic [N-1:0] sack, ack, err;
    prev = -1;
    for (int i = 0; i < N; i++) begin
      rem[i] = 2;
      drive_m(i, 1'b1, rnd64(), 1'($urandom_range(0, 1)), 1'b0, rnd64());
    end
    for (int t = 0; t < 4; t++) begin
      exp_o = rr_pick(m_stb_i, model_ptr);
      q = rnd64();
      slave_serve($urandom_range(1, 4), 0, q, owner, arb, adr, wd, we, sack, ack, err, qo, rc);
      checks++; if (owner !== exp_o) begin failures++; $display("FAIL alt_owner t=%0d got=%0d exp=%0d", t, owner, exp_o); end
      checks++; if (owner == prev) begin failures++; $display("FAIL alt_repeat t=%0d got=%0d exp!=%0d", t, owner, prev); end
      if (owner < 0) break;
      checks++; if (adr !== exp_adr[owner] || wd !== exp_d[owner])
        begin failures++; $display("FAIL alt_bus t=%0d got=%h/%h exp=%h/%h", t, adr, wd, exp_adr[owner], exp_d[owner]); end
      checks++; if (ack !== onehot(owner) || err !== '0 || qo !== q)
        begin failures++; $display("FAIL alt_resp t=%0d got ack=%b q=%h exp ack=%b q=%h", t, ack, qo, onehot(owner), q); end
      model_ptr = (owner + 1) % N;
      prev = owner;
      rem[owner]--;
      drive_m(owner, rem[owner] > 0, rnd64(), 1'($urandom_range(0, 1)), 1'b0, rnd64());
    end
    m_stb_i = '0;
    step();
  endtask

  task automatic test_lock();
    int owner, arb, rc; logic [PL-1:0] adr; logic [XL-1:0] wd, qo, q; logic we;
    logic [N-1:0] sack, ack, err;
    for (int t = 0; t < 3; t++) begin
      drive_m(1, 1'b1, rnd64(), 1'b1, (t < 2), rnd64());
      q = rnd64();
      slave_serve($urandom_range(1, 3), 0, q, owner, arb, adr, wd, we, sack, ack, err, qo, rc);
      if (t == 0) drive_m(0, 1'b1, rnd64(), 1'b0, 1'b0, rnd64());
      checks++; if (owner !== 1 || ack !== 2'b10)
        begin failures++; $display("FAIL lock_owner t=%0d got=%0d ack=%b exp=1 ack=10", t, owner, ack); end
      checks++; if (wd !== exp_d[1] || we !== 1'b1)
        begin failures++; $display("FAIL lock_wdata t=%0d got=%h exp=%h", t, wd, exp_d[1]); end
      if (t > 0) begin
        checks++; if (arb !== 0) begin failures++; $display("FAIL lock_no_rearb t=%0d got=%0d exp=0", t, arb); end
      end
    end
    m_stb_i[1] = 1'b0;
    model_ptr = 0;
    slave_serve(1, 0, rnd64(), owner, arb, adr, wd, we, sack, ack, err, qo, rc);
    m_stb_i = '0;
    checks++; if (owner !== rr_pick(2'b01, model_ptr) || arb !== 1)
      begin failures++; $display("FAIL lock_release got owner=%0d arb=%0d exp=0 arb=1", owner, arb); end
    model_ptr = 1;
    step();
  endtask

  task automatic test_timeout();
    int owner, arb, rc; logic [PL-1:0] adr; logic [XL-1:0] wd, qo; logic we;
    logic [N-1:0] sack, ack, err;
    drive_m(0, 1'b1, rnd64(), 1'b0, 1'b0, rnd64());
    step();
    drive_m(1, 1'b1, rnd64(), 1'b0, 1'b0, rnd64());
    slave_serve(0, 1, '0, owner, arb, adr, wd, we, sack, ack, err, qo, rc);
    m_stb_i[0] = 1'b0;
    checks++; if (owner !== 0) begin failures++; $display("FAIL to_owner got=%0d exp=0", owner); end
    checks++; if (rc !== TO || err !== 2'b01 || ack !== 2'b00)
      begin failures++; $display("FAIL to_err_pulse got cyc=%0d err=%b ack=%b exp cyc=%0d err=01 ack=00", rc, err, ack, TO); end
    model_ptr = 1;
    s_ack_i = 1'b1; s_q_i = rnd64();
    #1;
    checks++; if (m_ack_o !== '0 || m_err_o !== '0 || m_q_o !== '0)
      begin failures++; $display("FAIL to_late_ack got ack=%b err=%b q=%h exp=0", m_ack_o, m_err_o, m_q_o); end
    slave_serve(2, 0, rnd64(), owner, arb, adr, wd, we, sack, ack, err, qo, rc);
    m_stb_i = '0;
    checks++; if (owner !== rr_pick(2'b10, model_ptr) || arb !== 1 || ack !== 2'b10)
      begin failures++; $display("FAIL to_next_grant got owner=%0d arb=%0d ack=%b exp=1 arb=1 ack=10", owner, arb, ack); end
    model_ptr = 0;
    step();
  endtask

  task automatic test_ack_err();
    int o, owner, arb, rc; logic [PL-1:0] adr; logic [XL-1:0] wd, qo; logic we;
    logic [N-1:0] sack, ack, err;
    o = $urandom_range(0, N - 1);
    drive_m(o, 1'b1, rnd64(), 1'b0, 1'b0, rnd64());
    slave_serve($urandom_range(1, 3), 2, rnd64(), owner, arb, adr, wd, we, sack, ack, err, qo, rc);
    m_stb_i = '0;
    checks++; if (owner !== o || err !== onehot(o) || ack !== '0)
      begin failures++; $display("FAIL ack_err got owner=%0d err=%b ack=%b exp owner=%0d err=%b ack=0", owner, err, ack, o, onehot(o)); end
    model_ptr = (o + 1) % N;
    step();
  endtask

  task automatic test_random();
    int exp_o, owner, arb, rc, mode; logic [N-1:0] mask;
    logic [PL-1:0] adr; logic [XL-1:0] wd, qo, q; logic we; logic [N-1:0] sack, ack, err;
    for (int r = 0; r < 12; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) drive_m(i, mask[i], rnd64(), 1'($urandom_range(0, 1)), 1'b0, rnd64());
      exp_o = rr_pick(mask, model_ptr);
      mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      q = rnd64();
      slave_serve($urandom_range(1, 3), mode, q, owner, arb, adr, wd, we, sack, ack, err, qo, rc);
      m_stb_i = '0;
      checks++; if (owner !== exp_o || arb !== 1)
        begin failures++; $display("FAIL rnd_owner r=%0d got=%0d arb=%0d exp=%0d arb=1", r, owner, arb, exp_o); end
      if (owner < 0) break;
      checks++; if (adr !== exp_adr[owner] || wd !== exp_d[owner] || we !== exp_we[owner])
        begin failures++; $display("FAIL rnd_bus r=%0d got=%h/%h/%b exp=%h/%h/%b", r, adr, wd, we, exp_adr[owner], exp_d[owner], exp_we[owner]); end
      checks++; if (sack !== onehot(owner))
        begin failures++; $display("FAIL rnd_stb_ack r=%0d got=%b exp=%b", r, sack, onehot(owner)); end
      if (mode == 2) begin
        checks++; if (err !== onehot(owner) || ack !== '0)
          begin failures++; $display("FAIL rnd_err r=%0d got err=%b ack=%b exp err=%b", r, err, ack, onehot(owner)); end
      end else begin
        checks++; if (ack !== onehot(owner) || err !== '0 || qo !== q)
          begin failures++; $display("FAIL rnd_ack r=%0d got ack=%b q=%h exp ack=%b q=%h", r, ack, qo, onehot(owner), q); end
      end
      model_ptr = (owner + 1) % N;
    end
    step();
  endtask

  task automatic test_reset_wait();
    int owner, arb, rc; logic [PL-1:0] adr; logic [XL-1:0] wd, qo; logic we;
    logic [N-1:0] sack, ack, err;
    drive_m(0, 1'b1, rnd64(), 1'b0, 1'b0, rnd64());
    slave_serve(1, 0, rnd64(), owner, arb, adr, wd, we, sack, ack, err, qo, rc);
    m_stb_i = '0;
    step();
    drive_m(1, 1'b1, rnd64(), 1'b1, 1'b0, rnd64());
    step();
    s_stb_ack_i = 1'b1;
    step();
    s_stb_ack_i = 1'b0;
    #1;
    checks++; if (gnt_o !== 2'b10 || s_stb_o !== 1'b0)
      begin failures++; $display("FAIL rstw_in_wait got gnt=%b stb=%b exp gnt=10 stb=0", gnt_o, s_stb_o); end
    rst = 1'b1;
    m_stb_i = '0;
    step();
    rst = 1'b0;
    s_ack_i = 1'b1; s_q_i = rnd64() | 64'h1;
    #1;
    checks++; if (gnt_o !== '0 || m_ack_o !== '0 || m_err_o !== '0 || m_q_o !== '0 || s_stb_o !== 1'b0 || s_adri_o !== '0)
      begin failures++; $display("FAIL rstw_outputs got gnt=%b ack=%b err=%b q=%h stb=%b exp all 0", gnt_o, m_ack_o, m_err_o, m_q_o, s_stb_o); end
    s_ack_i = 1'b0; s_q_i = '0;
    model_ptr = 0;
    drive_m(0, 1'b1, rnd64(), 1'b0, 1'b0, rnd64());
    drive_m(1, 1'b1, rnd64(), 1'b0, 1'b0, rnd64());
    slave_serve(2, 0, 64'h1234, owner, arb, adr, wd, we, sack, ack, err, qo, rc);
    m_stb_i = '0;
    checks++; if (owner !== rr_pick(2'b11, model_ptr) || ack !== 2'b01 || qo !== 64'h1234)
      begin failures++; $display("FAIL rstw_regrant got owner=%0d ack=%b q=%h exp=0 ack=01 q=1234", owner, ack, qo); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_lock();
    test_timeout();
    test_ack_err();
    test_random();
    test_reset_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
